// File: rtl/mem_seq_pkg.sv
// Shared types and defaults for the relay-memory access sequencer.
package mem_seq_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  // Remaining-cycles count for one timed phase.
  typedef logic [3:0] phase_cnt_t;

  // The encodings are fixed because they are shown directly on the LED bus.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } phase_e;

  // The counter counts down to zero, so a phase of n cycles is loaded with n-1.
  function automatic phase_cnt_t cnt_init(input int unsigned n);
    return phase_cnt_t'(n - 1);
  endfunction

endpackage

// File: rtl/mem_phase_timer.sv
// Loadable 4-bit down-counter that times each phase of a memory access.
module mem_phase_timer
  import mem_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       zero
);

  phase_cnt_t cnt;

  // Load on phase entry, otherwise count down and stop at zero.
  always_ff @(posedge clk) begin
    if (reset)              cnt <= '0;
    else if (load)          cnt <= load_val;
    else if (cnt != '0)     cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_access_sequencer.sv
// Bus master for the relay-computer memory: runs one request at a time as a
// setup / strobe / hold cycle and returns a one-cycle completion pulse.
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DEF,
  parameter int DATA_W        = DATA_W_DEF,
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        phase
);

  // The 4-bit timer cannot represent phases outside 1..15.
  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
    $error("SETUP_CYCLES must be 1..15");
  end
  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
    $error("STROBE_CYCLES must be 1..15");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
    $error("HOLD_CYCLES must be 1..15");
  end

  localparam phase_cnt_t CNT_S = cnt_init(SETUP_CYCLES);
  localparam phase_cnt_t CNT_T = cnt_init(STROBE_CYCLES);
  localparam phase_cnt_t CNT_H = cnt_init(HOLD_CYCLES);

  phase_e            state, state_nx;
  logic              load;
  phase_cnt_t        load_val;
  logic              cnt_zero;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  mem_phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .zero     (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; the timer is reloaded whenever a timed phase is entered.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    load_val = '0;
    case (state)
      IDLE: if (req_valid) begin
        state_nx = SETUP;
        load     = 1'b1;
        load_val = CNT_S;
      end
      SETUP: if (cnt_zero) begin
        state_nx = STROBE;
        load     = 1'b1;
        load_val = CNT_T;
      end
      STROBE: if (cnt_zero) begin
        state_nx = HOLD;
        load     = 1'b1;
        load_val = CNT_H;
      end
      HOLD:    if (cnt_zero) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request capture and read-data return. The address register only changes
  // on acceptance, which is what keeps mem_addr stable through the access.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        wr_q   <= req_write;
        addr_q <= req_addr;
        if (req_write) wdata_q <= req_wdata;
      end
      // Sample on the edge that closes the last strobe cycle.
      if (state == STROBE && cnt_zero && !wr_q) rdata_q <= mem_rdata;
    end
  end

  // Bus outputs decoded from the current phase.
  always_comb begin
    req_ready    = (state == IDLE);
    resp_valid   = (state == DONE);
    mem_read     = (state == STROBE) && !wr_q;
    mem_write    = (state == STROBE) &&  wr_q;
    mem_wdata_oe = wr_q && (state inside {SETUP, STROBE, HOLD});
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    resp_rdata   = rdata_q;
    phase        = state;
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench: default-timing DUT plus a SETUP=3/STROBE=1/HOLD=2 DUT,
// both against a 32 KB memory model that ignores address bit 15.
module tb_mem_access_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        v1, w1, rdy1, rv1, mr1, mw1, oe1;
  logic [15:0] a1, ma1;
  logic [7:0]  d1, rdd1, mwd1, mrd1;
  logic [2:0]  ph1;
  logic        v2, w2, rdy2, rv2, mr2, mw2, oe2;
  logic [15:0] a2, ma2;
  logic [7:0]  d2, rdd2, mwd2, mrd2;
  logic [2:0]  ph2;

  int n_chk = 0;
  int n_pass = 0;

  mem_access_sequencer u_dut1 (
    .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_write(w1),
    .req_addr(a1), .req_wdata(d1), .resp_valid(rv1), .resp_rdata(rdd1),
    .mem_addr(ma1), .mem_read(mr1), .mem_write(mw1), .mem_wdata(mwd1),
    .mem_wdata_oe(oe1), .mem_rdata(mrd1), .phase(ph1)
  );

  mem_access_sequencer #(.SETUP_CYCLES(3), .STROBE_CYCLES(1), .HOLD_CYCLES(2)) u_dut2 (
    .clk(clk), .reset(reset), .req_valid(v2), .req_ready(rdy2), .req_write(w2),
    .req_addr(a2), .req_wdata(d2), .resp_valid(rv2), .resp_rdata(rdd2),
    .mem_addr(ma2), .mem_read(mr2), .mem_write(mw2), .mem_wdata(mwd2),
    .mem_wdata_oe(oe2), .mem_rdata(mrd2), .phase(ph2)
  );

  // Memory model: 15-bit decode, preloaded while reset is high.
  logic [7:0] mem [0:32767];
  assign mrd1 = mem[ma1[14:0]];
  assign mrd2 = mem[ma2[14:0]];

  always @(posedge clk) begin
    if (reset) begin
      mem[15'h0123] <= 8'hA5;
      mem[15'h0010] <= 8'h5E;
      mem[15'h0001] <= 8'h11;
    end else if (mw1) begin
      mem[ma1[14:0]] <= mwd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Bus invariants sampled every cycle on both DUTs.
  logic [15:0] p1_addr = '0, p2_addr = '0;
  logic [7:0]  p1_wd = '0;
  logic        p1_oe = 1'b0;
  always @(negedge clk) begin
    chk("rw_excl1", 32'(mr1 & mw1), 32'd0);
    chk("rw_excl2", 32'(mr2 & mw2), 32'd0);
    chk("strb_ph1", 32'((mr1 | mw1) && ph1 != 3'd2), 32'd0);
    chk("strb_ph2", 32'((mr2 | mw2) && ph2 != 3'd2), 32'd0);
    if (ph1 == 3'd2 || ph1 == 3'd3) chk("addr_hold1", 32'(ma1), 32'(p1_addr));
    if (ph2 == 3'd2 || ph2 == 3'd3) chk("addr_hold2", 32'(ma2), 32'(p2_addr));
    if (oe1 && p1_oe) chk("wd_hold1", 32'(mwd1), 32'(p1_wd));
    p1_addr <= ma1;
    p2_addr <= ma2;
    p1_wd   <= mwd1;
    p1_oe   <= oe1;
  end

  // Per-cycle trace of one access; bit c = cycle c after the acceptance edge.
  logic [7:0]  t_rd, t_wr, t_rv, t_rdy, t_oe;
  logic [15:0] t_addr [8];
  logic [7:0]  t_wd [8];

  // Called #1 after a rising edge with the selected DUT idle.
  task automatic run_acc(input bit sel, input logic w, input logic [15:0] a, input logic [7:0] d);
    if (!sel) begin v1 = 1'b1; w1 = w; a1 = a; d1 = d; end
    else      begin v2 = 1'b1; w2 = w; a2 = a; d2 = d; end
    @(posedge clk); #1;
    v1 = 1'b0; v2 = 1'b0;
    t_rd = '0; t_wr = '0; t_rv = '0; t_rdy = '0; t_oe = '0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (!sel) begin
        t_rd[c] = mr1; t_wr[c] = mw1; t_rv[c] = rv1; t_rdy[c] = rdy1; t_oe[c] = oe1;
        t_addr[c] = ma1; t_wd[c] = mwd1;
      end else begin
        t_rd[c] = mr2; t_wr[c] = mw2; t_rv[c] = rv2; t_rdy[c] = rdy2; t_oe[c] = oe2;
        t_addr[c] = ma2; t_wd[c] = mwd2;
      end
      @(posedge clk); #1;
    end
  endtask

  int acc_t [3];
  logic [7:0] rdv [3];
  int k, pulses, lowc;
  bit acc;

  initial begin
    reset = 1'b1;
    v1 = 0; w1 = 0; a1 = '0; d1 = '0;
    v2 = 0; w2 = 0; a2 = '0; d2 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state.
    @(negedge clk);
    chk("rst_ready", 32'(rdy1), 32'd1);
    chk("rst_resp", 32'(rv1), 32'd0);
    chk("rst_rdata", 32'(rdd1), 32'd0);
    chk("rst_addr", 32'(ma1), 32'd0);
    chk("rst_strobes", 32'({mr1, mw1, oe1}), 32'd0);
    chk("rst_wdata", 32'(mwd1), 32'd0);
    chk("rst_phase", 32'(ph1), 32'd0);
    @(posedge clk); #1;

    // Read with default timing.
    run_acc(1'b0, 1'b0, 16'h0123, 8'h00);
    chk("rd_strobe", 32'(t_rd), 32'h0C);
    chk("rd_nowrite", 32'(t_wr), 32'h00);
    chk("rd_resp", 32'(t_rv), 32'h20);
    chk("rd_ready", 32'(t_rdy), 32'hC0);
    chk("rd_oe", 32'(t_oe), 32'h00);
    chk("rd_addr_setup", 32'(t_addr[1]), 32'h0123);
    chk("rd_addr_hold", 32'(t_addr[4]), 32'h0123);
    chk("rd_data", 32'(rdd1), 32'hA5);

    // Write then read back at the top of the 32 KB space.
    run_acc(1'b0, 1'b1, 16'h7FFF, 8'h3C);
    chk("wr_strobe", 32'(t_wr), 32'h0C);
    chk("wr_noread", 32'(t_rd), 32'h00);
    chk("wr_oe", 32'(t_oe), 32'h1E);
    chk("wr_data_setup", 32'(t_wd[1]), 32'h3C);
    chk("wr_data_hold", 32'(t_wd[4]), 32'h3C);
    chk("wr_resp", 32'(t_rv), 32'h20);
    chk("wr_keeps_rdata", 32'(rdd1), 32'hA5);
    run_acc(1'b0, 1'b0, 16'h7FFF, 8'h00);
    chk("rb_strobe", 32'(t_rd), 32'h0C);
    chk("rb_data", 32'(rdd1), 32'h3C);

    // Back-to-back: three reads with req_valid held high.
    a1 = 16'h0123; w1 = 1'b0; v1 = 1'b1;
    k = 0; pulses = 0; lowc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      acc = rdy1 && v1;
      if (acc && k < 3) acc_t[k] = i;
      if (rv1) begin
        if (pulses < 3) rdv[pulses] = rdd1;
        pulses++;
      end
      if (!rdy1) lowc++;
      @(posedge clk); #1;
      if (acc) begin
        k++;
        if (k == 1)      a1 = 16'h7FFF;
        else if (k == 2) a1 = 16'h0001;
        else             v1 = 1'b0;
      end
    end
    chk("b2b_accepts", 32'(k), 32'd3);
    chk("b2b_gap01", 32'(acc_t[1] - acc_t[0]), 32'd6);
    chk("b2b_gap12", 32'(acc_t[2] - acc_t[1]), 32'd6);
    chk("b2b_pulses", 32'(pulses), 32'd3);
    chk("b2b_ready_low", 32'(lowc), 32'd15);
    chk("b2b_data0", 32'(rdv[0]), 32'hA5);
    chk("b2b_data1", 32'(rdv[1]), 32'h3C);
    chk("b2b_data2", 32'(rdv[2]), 32'h11);

    // Reset during the first strobe cycle of a read.
    v1 = 1'b1; w1 = 1'b0; a1 = 16'h0123;
    @(posedge clk); #1 v1 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid_pre", 32'(mr1), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_read", 32'(mr1), 32'd0);
    chk("rst_mid_ready", 32'(rdy1), 32'd1);
    chk("rst_mid_rdata", 32'(rdd1), 32'd0);
    chk("rst_mid_resp", 32'(rv1), 32'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rv1) pulses++;
    end
    chk("rst_mid_nopulse", 32'(pulses), 32'd0);
    @(posedge clk); #1;

    // Alternate timing; bit 15 passes through to the bus but is not decoded.
    run_acc(1'b1, 1'b0, 16'h8010, 8'h00);
    chk("sw_addr", 32'(t_addr[1]), 32'h8010);
    chk("sw_strobe", 32'(t_rd), 32'h10);
    chk("sw_resp", 32'(t_rv), 32'h80);
    chk("sw_ready", 32'(t_rdy), 32'h00);
    chk("sw_data", 32'(rdd2), 32'h5E);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
